// File: rtl/mem_arbiter.sv
// Two-requester (fetch F / load-store D) arbiter for a single-ported unified memory.
// Optional macro ARB_ROUND_ROBIN_EN: alternate the winner on contention instead of fixed D-over-F.
module mem_arbiter #(
   parameter int AW    = 16,
   parameter int DW    = 16,
   parameter int DEPTH = 256,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             f_req,
   input  logic [AW-1:0]    f_addr,
   output logic             f_gnt,
   output logic             f_rvalid,
   output logic [DW-1:0]    f_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [AW-1:0]    d_addr,
   input  logic [DW-1:0]    d_wdata,
   output logic             d_gnt,
   output logic             d_rvalid,
   output logic [DW-1:0]    d_rdata,
   output logic             addr_err,
   output logic             mem_enable,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   input  logic [DW-1:0]    mem_rdata,
   output logic             busy,
   output logic [CNT_W-1:0] contention_cnt
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   // One extra bit so DEPTH == 2**AW still compares correctly.
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   state_t          state;
   state_t          state_next;
   logic            lat_owner_d;
   logic            lat_we;
   logic [AW-1:0]   lat_addr;
   logic [DW-1:0]   lat_wdata;
   logic            in_range;
   logic            contended;
   logic            pick_d;

   assign in_range  = ({1'b0, lat_addr} < DEPTH_L);
   assign contended = (state == IDLE) && f_req && d_req;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_winner_d;

   always_ff @(posedge clock) begin
      if (!reset_n)
         last_winner_d <= 1'b0;
      else if (contended)
         last_winner_d <= d_gnt;
   end

   assign pick_d = !last_winner_d;
`else
   assign pick_d = 1'b1;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (f_req || d_req) state_next = ACCESS;
         ACCESS:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: every output gets a default before the case so no path can infer a latch.
   always_comb begin
      f_gnt      = 1'b0;
      d_gnt      = 1'b0;
      mem_enable = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (f_req && d_req) begin
               d_gnt = pick_d;
               f_gnt = !pick_d;
            end else begin
               f_gnt = f_req;
               d_gnt = d_req;
            end
         end
         ACCESS: begin
            if (in_range) begin
               mem_enable = 1'b1;
               mem_we     = lat_we;
               mem_addr   = lat_addr;
               mem_wdata  = lat_wdata;
            end
         end
         default: ;
      endcase
   end

   // NOTE: request latches are reset too; cheap flops, and a defined state eases debug.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         lat_owner_d <= 1'b0;
         lat_we      <= 1'b0;
         lat_addr    <= '0;
         lat_wdata   <= '0;
      end else if (d_gnt) begin
         lat_owner_d <= 1'b1;
         lat_we      <= d_we;
         lat_addr    <= d_addr;
         lat_wdata   <= d_wdata;
      end else if (f_gnt) begin
         lat_owner_d <= 1'b0;
         lat_we      <= 1'b0;
         lat_addr    <= f_addr;
         lat_wdata   <= '0;
      end
   end

   // Completion: mem_rdata is asynchronous, so it is valid at the edge closing ACCESS.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         f_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         addr_err <= 1'b0;
         f_rdata  <= '0;
         d_rdata  <= '0;
      end else begin
         f_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         addr_err <= 1'b0;
         if (state == ACCESS) begin
            addr_err <= !in_range;
            if (lat_owner_d) begin
               d_rvalid <= 1'b1;
               d_rdata  <= (in_range && !lat_we) ? mem_rdata : '0;
            end else begin
               f_rvalid <= 1'b1;
               f_rdata  <= in_range ? mem_rdata : '0;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n)
         contention_cnt <= '0;
      else if (contended && (contention_cnt != '1))
         contention_cnt <= contention_cnt + 1'b1;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single unified instruction/data memory between two requesters: the instruction-fetch unit (port F) and the load/store unit (port D).
- Sits between the CPU control path and the memory block.
- Registers each accepted request, then drives the memory's enable/writeEnable/address/writeData lines for exactly one cycle.
- Captures the memory's asynchronous read data and returns it to the owning requester.
- Rejects addresses outside the populated memory depth without touching memory.

Parameters:
- AW, 16, address width (matches the memory address port)
- DW, 16, data width (matches the memory data ports)
- DEPTH, 256, number of populated memory words; an address >= DEPTH is out of range
- CNT_W, 16, width of the contention counter

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  synchronous active-low reset
- f_req  in  1  fetch request, held until granted
- f_addr  in  AW  fetch address
- f_gnt  out  1  fetch request accepted this cycle (combinational)
- f_rvalid  out  1  one-cycle pulse, f_rdata valid
- f_rdata  out  DW  fetch read data
- d_req  in  1  data request, held until granted
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  one-cycle completion pulse for reads and writes
- d_rdata  out  DW  data read data (0 on writes)
- addr_err  out  1  one-cycle pulse, coincident with rvalid, when the completed access was out of range
- mem_enable  out  1  to memory enable
- mem_we  out  1  to memory writeEnable
- mem_addr  out  AW  to memory address
- mem_wdata  out  DW  to memory writeData
- mem_rdata  in  DW  from memory readData (asynchronous read)
- busy  out  1  FSM not in IDLE
- contention_cnt  out  CNT_W  cycles with f_req and d_req both high while in IDLE, saturating

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - FSM goes to IDLE.
  - All outputs go to 0: rvalids, addr_err, mem_* lines, rdata registers and contention_cnt.
  - Reset has priority over every other event.
- FSM states: IDLE and ACCESS.
- IDLE:
  - If any request is pending, the winner's gnt is asserted combinationally in the same cycle.
  - On that edge the arbiter latches owner, we, addr and wdata, and moves to ACCESS.
  - With no request pending, the FSM stays in IDLE.
- ACCESS (exactly one cycle):
  - If the latched address is < DEPTH: mem_enable=1, mem_we = latched we, and mem_addr/mem_wdata = latched values.
  - If the latched address is >= DEPTH: mem_enable=0 and mem_we=0.
  - At the closing edge:
    - The owner's rdata register loads mem_rdata for an in-range read, otherwise 0.
    - The owner's rvalid is set for the next cycle; addr_err is set if the address was out of range.
    - The FSM returns to IDLE.
- Latency and throughput:
  - gnt in cycle N, memory access in cycle N+1, rvalid/rdata in cycle N+2.
  - A new grant may occur in cycle N+2, so sustained throughput is 1 access per 2 cycles.
- The mem_* outputs are 0 in every cycle other than ACCESS.
- gnt is never asserted outside IDLE; a requester must keep req and its payload stable until gnt.
- Arbitration: fixed priority, D over F (loads and stores complete before the next fetch).
- Simultaneous events:
  - f_req and d_req both high in IDLE: d_gnt=1 and f_gnt=0; F stays pending; contention_cnt increments.
  - contention_cnt holds at all-ones.
- Reset during ACCESS:
  - The in-flight access is aborted and no rvalid is issued.
  - The memory write still commits if reset_n is sampled low on the same edge that ends ACCESS, since mem_we was high during ACCESS; the bench must not check that location.
- f_rdata and d_rdata hold their value until the next completion for that port.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on contention in IDLE, grant the port that did not win the last contended arbitration. A last_winner flag resets to F, so D wins the first contention. Uncontended grants do not change last_winner.
- Not defined: fixed D-over-F priority as above, and no last_winner state exists.
- contention_cnt behaves identically in both builds.

Test Plan:
- Single fetch, mem[0x0005]=0xBEEF: f_req with f_addr=0x0005 in IDLE -> f_gnt same cycle; mem_enable=1, mem_addr=0x0005 next cycle; f_rvalid=1 with f_rdata=0xBEEF two cycles after gnt; busy=1 for exactly one cycle.
- Write then read: d_req, d_we=1, d_addr=0x0010, d_wdata=0x1234 -> mem_we=1 for one cycle, d_rvalid pulse with d_rdata=0. Follow with a read of 0x0010 -> d_rdata=0x1234.
- Contention, fixed priority: f_req and d_req held high together, then each request drops the cycle after its own gnt -> D granted first, F granted 2 cycles later; contention_cnt=1. Under ARB_ROUND_ROBIN_EN, a second contention afterwards grants F first.
- Out of range: d_req read at d_addr=0x0100 with DEPTH=256 -> mem_enable stays 0; d_rvalid=1, addr_err=1, d_rdata=0.
- Reset mid-access: assert reset_n=0 in the ACCESS cycle of a fetch -> no f_rvalid; all outputs 0 next cycle; FSM in IDLE; a new request is granted normally after release.
- Saturation: CNT_W=4, hold both requests for 40 arbitration rounds -> contention_cnt stops at 0xF.
